// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STROBE    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned STB_LEN_DEF = 4;
  localparam int unsigned BUSY_TO_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first active request at or after
// ptr (wrapping) wins; output is one-hot, all zero when nothing is requested.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner
);

  logic [IW-1:0] idx;
  logic          found;

  // Scan from the pointer upward and take the first requester seen.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx transmitter among NUM_REQ requesters: grants round-robin,
// strobes tx_int for STB_LEN cycles, then tracks tx_busy to signal completion.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned STB_LEN = STB_LEN_DEF,
  parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             tx_data,
  output logic                   tx_int,
  input  logic                   tx_busy,
  output logic                   err_to
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = $clog2(STB_LEN + 1);
  localparam int unsigned TW = $clog2(BUSY_TO + 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic [7:0]           tx_data_d;
  logic                 tx_int_d, err_to_d;
  logic [SW-1:0]        stb_cnt, stb_cnt_d;
  logic [TW-1:0]        to_cnt, to_cnt_d;
  logic [IW-1:0]        ptr, ptr_d;
  logic [IW-1:0]        win_idx, win_idx_d;

  logic [NUM_REQ-1:0]   arb_win;
  logic [IW-1:0]        arb_idx;
  logic [7:0]           arb_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_win)
  );

  // Index and byte of the arbiter's current pick.
  always_comb begin
    arb_idx  = '0;
    arb_data = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_win[i]) begin
        arb_idx  = IW'(i);
        arb_data = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt;
    done_d    = '0;
    tx_data_d = tx_data;
    tx_int_d  = tx_int;
    err_to_d  = 1'b0;
    stb_cnt_d = stb_cnt;
    to_cnt_d  = to_cnt;
    ptr_d     = ptr;
    win_idx_d = win_idx;

    case (state_q)
      IDLE: begin
        // A transmitter still busy from earlier traffic holds off new grants.
        if (|req && !tx_busy) begin
          gnt_d     = arb_win;
          tx_data_d = arb_data;
          win_idx_d = arb_idx;
          tx_int_d  = 1'b1;
          stb_cnt_d = SW'(1);
          state_d   = STROBE;
        end
      end

      STROBE: begin
        if (stb_cnt == SW'(STB_LEN)) begin
          tx_int_d = 1'b0;
          to_cnt_d = '0;
          state_d  = WAIT_BUSY;
        end else begin
          stb_cnt_d = stb_cnt + SW'(1);
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt >= TW'(BUSY_TO - 1)) begin
          // Transmitter never started: finish the transfer with an error flag.
          to_cnt_d = TW'(BUSY_TO);
          err_to_d = 1'b1;
          done_d   = gnt;
          gnt_d    = '0;
          ptr_d    = IW'((32'(win_idx) + 32'd1) % NUM_REQ);
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt + TW'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = gnt;
          gnt_d   = '0;
          ptr_d   = IW'((32'(win_idx) + 32'd1) % NUM_REQ);
          state_d = IDLE;
        end
      end

      default: begin
        gnt_d    = '0;
        tx_int_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      done    <= '0;
      tx_data <= 8'h00;
      tx_int  <= 1'b0;
      err_to  <= 1'b0;
      stb_cnt <= '0;
      to_cnt  <= '0;
      ptr     <= '0;
      win_idx <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      done    <= done_d;
      tx_data <= tx_data_d;
      tx_int  <= tx_int_d;
      err_to  <= err_to_d;
      stb_cnt <= stb_cnt_d;
      to_cnt  <= to_cnt_d;
      ptr     <= ptr_d;
      win_idx <= win_idx_d;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_tx transmitter (range 2..8).
REQ-002 Parameter STB_LEN, default 4, number of clk cycles tx_int is held high per byte.
REQ-003 Parameter BUSY_TO, default 64, maximum clk cycles to wait for tx_busy rise after strobe release.
REQ-004 Port clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port req  in  NUM_REQ  per-requester transmit request, level, held until matching done.
REQ-007 Port req_data  in  8*NUM_REQ  byte per requester; requester i in bits [8i+7:8i].
REQ-008 Port gnt  out  NUM_REQ  one-hot grant, high for the whole transfer.
REQ-009 Port done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 Port tx_data  out  8  byte to transmitter; stable from grant until done.
REQ-011 Port tx_int  out  1  transmit strobe to transmitter; the transmitter starts on its falling edge.
REQ-012 Port tx_busy  in  1  transmitter busy (its bps_start); high while the frame is shifted out.
REQ-013 Port err_to  out  1  one-cycle pulse on busy-rise timeout.

Function
REQ-014 FSM states SHALL be IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: when any req is high, the block SHALL select a winner round-robin, starting at the index after the last granted requester.
REQ-016 On the selection edge: gnt SHALL go one-hot, tx_data SHALL capture the winner's req_data, tx_int SHALL go high, and the state SHALL become STROBE.
REQ-017 gnt, tx_data and tx_int SHALL all be valid in the first cycle after the req sampling edge (latency 1).
REQ-018 STROBE: tx_int SHALL stay high for exactly STB_LEN cycles, then go low; the state SHALL then become WAIT_BUSY with the timeout counter cleared.
REQ-019 WAIT_BUSY: when tx_busy=1, the state SHALL become WAIT_DONE.
REQ-020 WAIT_BUSY timeout: if BUSY_TO cycles elapse with tx_busy=0, the block SHALL pulse err_to and pulse done for the granted requester, then release gnt and return to IDLE.
REQ-021 WAIT_DONE: on the first cycle with tx_busy=0, the block SHALL pulse done[winner] for one cycle, deassert gnt in that same cycle, update the round-robin pointer, and return to IDLE.
REQ-022 IDLE SHALL last at least one cycle between transfers (no back-to-back grant in the done cycle).
REQ-023 If req[winner] drops mid-transfer, the transfer SHALL still complete with a normal done pulse; req changes on other lines SHALL be ignored until IDLE.
REQ-024 If several req lines are high in IDLE, the round-robin order SHALL be used; a single persistent requester SHALL be re-granted each round.
REQ-025 tx_busy already high when entering IDLE SHALL block a new grant until it goes low.
REQ-026 The timeout counter width SHALL be clog2(BUSY_TO+1); the counter SHALL saturate and never wrap.

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, gnt=0, done=0, tx_data=8'h00, tx_int=0, err_to=0, counters=0, and the pointer set so requester 0 has highest priority.
REQ-028 A reset asserted mid-transfer SHALL abort the transfer with no done pulse; tx_int SHALL fall in the same cycle.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum and the default values for NUM_REQ, STB_LEN and BUSY_TO.
REQ-030 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs req, pointer; output one-hot winner), purely combinational.

Verification
REQ-031 Single request: req=4'b0010, data1=8'hA5, tx_busy high 3 cycles after tx_int falls, for 20 cycles -> gnt=0010, tx_data=A5, tx_int high exactly 4 cycles, done[1] one pulse on the tx_busy fall.
REQ-032 Contention: req=4'b1111 held -> grants in order 0,1,2,3,0, each with the correct byte, and ≥1 IDLE cycle between grants.
REQ-033 Timeout: tx_busy held 0 -> err_to pulse and done pulse 64 cycles after tx_int falls, gnt released, next request served normally.
REQ-034 Requester drop: req[2] deasserted during WAIT_DONE -> transfer completes, done[2] pulses, no grant to 2 afterwards.
REQ-035 Reset mid-transfer: rst=1 during STROBE -> tx_int=0 and gnt=0 next cycle, no done, first grant after reset goes to requester 0 when req=4'b1111.
